// File: rtl/seg_reader.sv
// Purpose: samples a multiplexed active-low 7-segment display and rebuilds the four hex digits it shows.
// Latency: out_valid rises STABLE_CNT+2 cycles after the input change that completes the fourth digit.
// Backpressure: frame held until out_ready; a frame completed while one is still held is dropped and flags overrun.
module seg_reader #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CNT);

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        pair_ok, same, accept;
  logic [1:0]  sel;
  logic [6:0]  seg_hi;
  logic [3:0]  nib;
  logic        nib_err;
  logic [15:0] shadow_val_q;
  logic [3:0]  shadow_err_q;
  logic [3:0]  mask_q, mask_d;
  logic        publish;
  logic [15:0] value_q;
  logic [3:0]  err_q;
  logic        vld_q, ovr_q;

  // Register the raw display lines once and remember the previous registered pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      prev_q <= 11'h7FF;
      cnt_q  <= 8'd0;
    end else begin
      an_q   <= an_n;
      seg_q  <= seg_n;
      prev_q <= {an_q, seg_q};
      cnt_q  <= cnt_d;
    end
  end

  // Digit select must be one-hot-low; anything else is a gap between digits.
  always_comb begin
    pair_ok = 1'b1;
    sel     = 2'd0;
    case (an_q)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: pair_ok = 1'b0;
    endcase
  end

  // Run length of the current registered pair; accept the digit once when it reaches the threshold.
  always_comb begin
    same  = ({an_q, seg_q} == prev_q);
    cnt_d = 8'd0;
    if (pair_ok) begin
      if (same) cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
      else      cnt_d = 8'd1;
    end
    // A saturated counter holding at the threshold must not re-accept.
    accept = pair_ok && (cnt_d == STABLE_LIM) && !(same && cnt_q == 8'hFF);
  end

  // Segment pattern (active-high a..g) to hex nibble; unknown patterns decode to 0 with an error.
  always_comb begin
    seg_hi  = ~seg_q;
    nib     = 4'h0;
    nib_err = 1'b0;
    case (seg_hi)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      default:    nib_err = 1'b1;
    endcase
  end

  // Capture mask: cleared on publish, an accept in the same cycle starts the next frame.
  always_comb begin
    publish = (mask_q == 4'hF);
    mask_d  = publish ? 4'h0 : mask_q;
    if (accept) mask_d[sel] = 1'b1;
  end

  // Shadow frame assembled digit by digit; later accepts of the same digit overwrite.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_q <= 16'h0000;
      shadow_err_q <= 4'h0;
      mask_q       <= 4'h0;
    end else begin
      mask_q <= mask_d;
      if (accept) begin
        shadow_val_q[{sel, 2'b00} +: 4] <= nib;
        shadow_err_q[sel]               <= nib_err;
      end
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 16'h0000;
      err_q   <= 4'h0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (publish) begin
      if (!vld_q || out_ready) begin
        value_q <= shadow_val_q;
        err_q   <= shadow_err_q;
        vld_q   <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (vld_q && out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign value     = value_q;
  assign digit_err = err_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_reader.sv
module tb_seg_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  always #5 clk = ~clk;

  seg_reader #(.STABLE_CNT(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .value     (value),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Active-high a..g pattern for each hex digit.
  function automatic logic [6:0] pat(input int d);
    case (d)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
      10: return 7'b1110111;
      11: return 7'b0011111;
      12: return 7'b1001110;
      13: return 7'b0111101;
      14: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned at;
    logic [15:0] v;
    logic [3:0]  e;
  } pub_t;

  pub_t        pq[$];
  int unsigned edge_n = 0;
  logic [10:0] m_last = 11'h7FF;
  int          m_run  = 0;
  logic [15:0] m_sval = '0;
  logic [3:0]  m_serr = '0;
  logic [3:0]  m_mask = '0;
  logic [15:0] e_val  = '0;
  logic [3:0]  e_err  = '0;
  logic        e_vld  = 1'b0;
  logic        e_ovr  = 1'b0;

  always @(posedge clk) begin
    logic [10:0] pair;
    logic [6:0]  hi;
    logic        ok, acc, err;
    int          prev_run, idx, nib;
    pub_t        p;
    edge_n++;
    if (rst) begin
      pq.delete();
      m_last = 11'h7FF;
      m_run  = 0;
      m_sval = '0;
      m_serr = '0;
      m_mask = '0;
      e_val  = '0;
      e_err  = '0;
      e_vld  = 1'b0;
      e_ovr  = 1'b0;
    end else begin
      // output side: a frame scheduled for this edge, else the handshake
      if (pq.size() > 0 && pq[0].at == edge_n) begin
        p = pq.pop_front();
        if (!e_vld || out_ready) begin
          e_val = p.v;
          e_err = p.e;
          e_vld = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (e_vld && out_ready) begin
        e_vld = 1'b0;
      end
      // sample side: run length of identical samples with a one-hot-low select
      pair     = {an_n, seg_n};
      ok       = ($countones(~an_n) == 1);
      prev_run = m_run;
      if (!ok)                 m_run = 0;
      else if (pair == m_last) m_run = (m_run < 255) ? m_run + 1 : 255;
      else                     m_run = 1;
      acc    = ok && (m_run == S) && !(pair == m_last && prev_run == 255);
      m_last = pair;
      if (acc) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!an_n[i]) idx = i;
        hi  = ~seg_n;
        nib = 0;
        err = 1'b1;
        for (int d = 0; d < 16; d++) if (pat(d) == hi) begin nib = d; err = 1'b0; end
        m_sval[idx*4 +: 4] = 4'(nib);
        m_serr[idx]        = err;
        m_mask[idx]        = 1'b1;
        if (m_mask == 4'hF) begin
          pq.push_back('{edge_n + 2, m_sval, m_serr});
          m_mask = 4'h0;
        end
      end
    end
  end

  // Every cycle after the first reset, the DUT outputs must equal the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_value",     32'(value),     32'(e_val));
      check("cyc_digit_err", 32'(digit_err), 32'(e_err));
      check("cyc_out_valid", 32'(out_valid), 32'(e_vld));
      check("cyc_overrun",   32'(overrun),   32'(e_ovr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic show(input int d, input int v, input int n);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    an_n  = a;
    seg_n = ~pat(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_vld(input string name, input int max);
    int c;
    c = 0;
    while (!out_valid && c < max) begin
      @(negedge clk);
      c++;
    end
    if (!out_valid) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int c;
    logic [3:0] bad;
    rst       = 1'b1;
    an_n      = 4'hF;
    seg_n     = 7'h7F;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_value",  32'(value),     32'h0);
    check("rst_err",    32'(digit_err), 32'h0);
    check("rst_valid",  32'(out_valid), 32'h0);
    check("rst_overrun",32'(overrun),   32'h0);
    rst = 1'b0;

    // basic scan, latency and one-cycle pulse
    idle(2);
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4);
    an_n = 4'b0111; seg_n = ~pat(4);
    c = 0;
    do begin @(negedge clk); c++; end while (!out_valid && c < 20);
    check("latency",       32'(c),         32'(S + 2));
    check("frame1_value",  32'(value),     32'h4321);
    check("frame1_err",    32'(digit_err), 32'h0);
    check("model_frame1",  32'(e_val),     32'h4321);
    @(negedge clk);
    check("frame1_pulse",  32'(out_valid), 32'h0);
    idle(3);

    // short dwell on digit 2 does not count
    do_reset();
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 3); show(3, 4, 4);
    idle(4);
    check("short_no_frame", 32'(out_valid), 32'h0);
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4);
    idle(1);
    wait_vld("short_timeout", 10);
    check("short_value", 32'(value), 32'h4321);
    idle(3);

    // blank digit 1
    do_reset();
    show(0, 1, 4);
    an_n = 4'b1101; seg_n = 7'h7F; repeat (4) @(negedge clk);
    show(2, 3, 4); show(3, 4, 4);
    idle(1);
    wait_vld("blank_timeout", 10);
    check("blank_value", 32'(value),     32'h4301);
    check("blank_err",   32'(digit_err), 32'b0010);
    check("model_blank_err", 32'(e_err), 32'b0010);
    idle(3);

    // invalid selects keep the partial mask
    do_reset();
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4);
    an_n = 4'b0011; seg_n = ~pat(5); repeat (10) @(negedge clk);
    idle(10);
    check("invalid_no_frame", 32'(out_valid), 32'h0);
    show(3, 4, 4);
    idle(1);
    wait_vld("invalid_timeout", 10);
    check("invalid_value", 32'(value), 32'h4321);
    idle(3);

    // overrun with consumer stalled
    do_reset();
    out_ready = 1'b0;
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4); show(3, 4, 4);
    idle(1);
    wait_vld("ovr_timeout", 10);
    check("ovr_first_value", 32'(value),   32'h4321);
    check("ovr_not_yet",     32'(overrun), 32'h0);
    show(0, 13, 4); show(1, 12, 4); show(2, 11, 4); show(3, 10, 4);
    idle(4);
    check("ovr_held_value", 32'(value),     32'h4321);
    check("ovr_held_valid", 32'(out_valid), 32'h1);
    check("ovr_flag",       32'(overrun),   32'h1);
    check("model_ovr",      32'(e_ovr),     32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    check("ovr_drop_valid", 32'(out_valid), 32'h0);
    check("ovr_sticky",     32'(overrun),   32'h1);
    idle(3);

    // reset mid-frame discards partial capture
    do_reset();
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4);
    do_reset();
    check("midrst_value",   32'(value),     32'h0);
    check("midrst_valid",   32'(out_valid), 32'h0);
    check("midrst_overrun", 32'(overrun),   32'h0);
    show(3, 4, 4);
    idle(10);
    check("midrst_no_frame", 32'(out_valid), 32'h0);

    // reset while a frame is held
    out_ready = 1'b0;
    show(0, 5, 4); show(1, 6, 4); show(2, 7, 4); show(3, 8, 4);
    idle(1);
    wait_vld("hold_timeout", 10);
    do_reset();
    check("hold_rst_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;

    // randomized scans against the model
    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      c = int'($urandom_range(0, 99));
      if (c < 3) begin
        do_reset();
      end else if (c < 13) begin
        case ($urandom_range(0, 4))
          0: bad = 4'hF;
          1: bad = 4'h0;
          2: bad = 4'b0011;
          3: bad = 4'b1010;
          default: bad = 4'b1100;
        endcase
        an_n  = bad;
        seg_n = 7'($urandom_range(0, 127));
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end else if (c < 25) begin
        show(int'($urandom_range(0, 3)), 0, 0);
        seg_n = 7'($urandom_range(0, 127));
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end else begin
        show(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(2, 6)));
      end
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
